// File: rtl/adc_capture.sv
// adc_capture: ADC clock generation, fixed-phase sampling, pipeline-latency skip and show-ahead FIFO.
// Define ADC_AVG4_EN to push the truncated mean of every 4 captures instead of each capture.
module adc_capture #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned SKIP       = 3,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_en,
    input  logic [DATA_W-1:0]             i_ad_data,
    output logic                          o_adclk,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    input  logic                          i_clr_ovf,
    output logic [15:0]                   o_smp_cnt
);

    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned SKIP_W = (SKIP < 1) ? 1 : $clog2(SKIP + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [DIV_W-1:0]  div_q, div_d;
    logic              adclk_q, adclk_d;
    logic [DATA_W-1:0] ad_q;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              strobe, capture;

    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              valid, pop, push, drop;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    // Divider output is registered so o_adclk lines up with div_q (high when div_q >= CLK_DIV/2).
    always_comb begin
        div_d = '0;
        if (i_en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
        adclk_d = i_en && (div_d >= DIV_HALF);
    end

    // First high-phase cycle: ad_q holds the pins from the last low-phase cycle.
    assign strobe  = i_en && (div_q == DIV_HALF);
    assign capture = strobe && (skip_q == '0);

    always_comb begin
        skip_d = skip_q;
        if (!i_en) begin
            skip_d = SKIP_W'(SKIP);
        end else if (strobe && (skip_q != '0)) begin
            skip_d = skip_q - 1'b1;
        end
    end

`ifdef ADC_AVG4_EN
    localparam int unsigned ACC_W = DATA_W + 2;

    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [1:0]       acc_n_q, acc_n_d;

    assign acc_sum = acc_q + ACC_W'(ad_q);

    always_comb begin
        acc_d   = acc_q;
        acc_n_d = acc_n_q;
        wr_req  = 1'b0;
        wr_data = acc_sum[ACC_W-1:2];
        if (!i_en) begin
            acc_d   = '0;
            acc_n_d = '0;
        end else if (capture) begin
            if (acc_n_q == 2'd3) begin
                acc_d   = '0;
                acc_n_d = '0;
                wr_req  = 1'b1;
            end else begin
                acc_d   = acc_sum;
                acc_n_d = acc_n_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q   <= '0;
            acc_n_q <= '0;
        end else begin
            acc_q   <= acc_d;
            acc_n_q <= acc_n_d;
        end
    end
`else
    assign wr_req  = capture;
    assign wr_data = ad_q;
`endif

    assign valid = (level_q != '0);
    assign pop   = valid && i_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push  = wr_req && ((level_q != LVL_FULL) || pop);
    assign drop  = wr_req && !push;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        ovf_d = drop | (ovf_q & ~i_clr_ovf);
        cnt_d = push ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q    <= '0;
            adclk_q  <= 1'b0;
            ad_q     <= '0;
            skip_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            div_q    <= div_d;
            adclk_q  <= adclk_d;
            ad_q     <= i_ad_data;
            skip_q   <= skip_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign o_adclk    = adclk_q;
    assign o_valid    = valid;
    assign o_data     = valid ? mem[rd_ptr_q] : '0;
    assign o_level    = level_q;
    assign o_overflow = ovf_q;
    assign o_smp_cnt  = cnt_q;

endmodule

// File: doc/adc_capture.md
Name: adc_capture

Overview:
- Capture front end for the 8-bit ADC on the AD/DA add-on board.
- Generates the ADC sample clock from the system clock and registers ADC data at a fixed phase.
- Skips the converter's pipeline latency after enable, then buffers samples in a small show-ahead FIFO.
- Presents samples as a valid/ready stream to downstream processing (DAC path, Wi-Fi/ESP32 readout).

Parameters:
- DATA_W, 8, ADC sample width.
- CLK_DIV, 4, i_clk cycles per ADC clock period; even, >= 2.
- SKIP, 3, samples discarded after each enable (ADC pipeline latency).
- FIFO_DEPTH, 16, sample buffer entries; power of 2.

Ports:
- i_clk  in  1  system clock (25 MHz board clock)
- i_rst_n  in  1  asynchronous active-low reset
- i_en  in  1  capture enable
- i_ad_data  in  DATA_W  ADC parallel data pins
- o_adclk  out  1  ADC sample clock
- o_data  out  DATA_W  head-of-FIFO sample
- o_valid  out  1  o_data holds a sample
- i_ready  in  1  consumer accepts o_data
- o_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- o_overflow  out  1  sticky: a sample was dropped on a full FIFO
- i_clr_ovf  in  1  clears o_overflow
- o_smp_cnt  out  16  accepted-sample counter, wraps at 0xFFFF->0

Behaviour:
- Reset (async, i_rst_n=0) clears everything:
  - o_adclk=0, o_valid=0, o_data=0, o_level=0, o_overflow=0, o_smp_cnt=0.
  - Divider, skip counter and FIFO pointers return to 0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while i_en=1.
  - o_adclk is registered: 1 when div_cnt >= CLK_DIV/2, else 0. The ADC clock is 50% duty, low phase first.
  - i_en=0: div_cnt held at 0 and o_adclk=0 from the next edge.
- Input path: ad_q <= i_ad_data every cycle (single IOB register).
- Sample strobe:
  - Fires on the cycle with div_cnt==CLK_DIV/2 and i_en=1.
  - ad_q then holds the pins as sampled in the last low-phase cycle, just before the ADC rising edge.
- Skip:
  - skip_cnt is loaded with SKIP whenever i_en=0.
  - While skip_cnt>0, each strobe decrements it and the sample is discarded.
  - Once skip_cnt=0, every strobe is a capture.
- FIFO (show-ahead):
  - o_data is mem[rd_ptr] whenever o_valid=1.
  - o_valid = (level != 0).
  - Pop when o_valid && i_ready.
  - Push on capture if level<FIFO_DEPTH, or if level==FIFO_DEPTH and a pop occurs in the same cycle; the level is then unchanged.
  - A capture with the FIFO full and no pop is dropped and sets o_overflow.
  - Pointers wrap modulo FIFO_DEPTH. o_level is updated the cycle after push/pop.
  - Push with the FIFO empty: o_valid rises the cycle after the capture strobe, giving 2 i_clk cycles from pin sampling to o_valid.
- Overflow: i_clr_ovf=1 clears the flag; an overflow event in the same cycle wins (flag stays 1).
- o_smp_cnt increments on every pushed capture. Dropped and skipped samples are not counted.
- i_en deasserted mid-stream:
  - No further strobes.
  - FIFO contents stay valid and drainable.
  - Re-enable restarts the divider at 0 and skips SKIP samples again.
- o_data is unchanged while o_valid=1 and i_ready=0.

Optional Feature:
- Macro: ADC_AVG4_EN.
- Defined:
  - Captures are accumulated in a 10-bit sum.
  - Every 4th capture, sum[9:2] (truncating) is pushed as one sample, and the sum clears.
  - Output rate is 1/4 of the ADC rate.
  - o_smp_cnt counts pushed averages.
  - Disabling i_en discards a partial accumulation.
- Undefined: every capture is pushed directly; no accumulator logic is present.

Test Plan:
- Reset: assert i_rst_n=0 mid-capture -> o_adclk, o_valid, o_level, o_overflow, o_smp_cnt all 0 immediately, without waiting for a clock edge.
- Stream (CLK_DIV=4, SKIP=3):
  - Stimulus: i_en=1, i_ready=1, i_ad_data ramp 0,1,2,... stepping just after each o_adclk rise.
  - Required: o_adclk period 4 cycles with 2 high; first 3 values discarded; o_data sequence 3,4,5,... with no gaps; o_smp_cnt tracks.
- Overflow: i_ready=0 for 20 captures -> o_level=16, o_overflow=1, o_smp_cnt=16. Then i_ready=1 -> exactly the first 16 samples drain in order.
- Clear race: i_clr_ovf=1 in the cycle of a dropped capture -> o_overflow stays 1. i_clr_ovf=1 on a later cycle -> o_overflow=0.
- Full with simultaneous pop and push: level 16, i_ready=1 in a capture cycle -> level stays 16, no overflow, ordering preserved.
- ADC_AVG4_EN: after skip, captures 10,11,12,13 -> one sample 11 (46>>2); i_en dropped after 2 captures of the next group -> nothing pushed.
